// File: rtl/activation_cache.sv
// Activation history buffer for a dilated causal conv1d layer: keeps the last
// 3*DILATION input vectors and presents x[t], x[t-K], x[t-2K], x[t-3K] as taps.
module activation_cache #(
    parameter int W        = 16,
    parameter int D        = 4,
    parameter int DILATION = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [D*W-1:0]   packed_in,
    input  logic             in_v,
    output logic             in_ready,
    output logic [D*W-1:0]   packed_a0,
    output logic [D*W-1:0]   packed_a1,
    output logic [D*W-1:0]   packed_a2,
    output logic [D*W-1:0]   packed_a3,
    output logic             out_v
);

    localparam int L  = 3 * DILATION;
    localparam int AW = $clog2(L);
    localparam int FW = $clog2(L + 1);
    localparam int VW = D * W;

    localparam logic [AW:0]   L_X   = (AW + 1)'(L);
    localparam logic [AW-1:0] K1_A  = AW'(DILATION);
    localparam logic [AW-1:0] K2_A  = AW'(2 * DILATION);
    localparam logic [AW-1:0] LAST  = AW'(L - 1);
    localparam logic [FW-1:0] F_K1  = FW'(DILATION);
    localparam logic [FW-1:0] F_K2  = FW'(2 * DILATION);
    localparam logic [FW-1:0] F_L   = FW'(L);

    typedef enum logic [2:0] {IDLE, FETCH, CAP2, CAP1, CAP0} state_t;

    state_t          state;
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rd_addr;
    logic [FW-1:0]   fill;
    logic [VW-1:0]   rd_data;
    logic [VW-1:0]   stage1;
    logic [VW-1:0]   stage2;
    logic [VW-1:0]   stage3;
    logic [VW-1:0]   mem [L];

    // (a - b) mod L for a, b < L; L is generally not a power of two.
    function automatic logic [AW-1:0] addr_sub(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] t;
        t = {1'b0, a} + L_X - {1'b0, b};
        if (t >= L_X)
            t = t - L_X;
        return t[AW-1:0];
    endfunction

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [VW-1:0] mask_tap(input logic [VW-1:0] v, input logic ok);
        return ok ? v : '0;
    endfunction

    // Storage: one write port, registered read every clock.
    always_ff @(posedge clk) begin
        if (state == CAP0)
            mem[wp] <= stage3;
        rd_data <= mem[rd_addr];
    end

    // Tap capture registers; fill is unchanged until CAP0 so it is the pre-write count.
    always_ff @(posedge clk) begin
        case (state)
            IDLE:    if (in_v) stage3 <= packed_in;
            CAP2:    stage2 <= mask_tap(rd_data, fill >= F_K1);
            CAP1:    stage1 <= mask_tap(rd_data, fill >= F_K2);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wp        <= '0;
            rd_addr   <= '0;
            fill      <= '0;
            out_v     <= 1'b0;
            in_ready  <= 1'b1;
            packed_a0 <= '0;
            packed_a1 <= '0;
            packed_a2 <= '0;
            packed_a3 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_v) begin
                        rd_addr  <= addr_sub(wp, K1_A);
                        out_v    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    rd_addr <= addr_sub(wp, K2_A);
                    state   <= CAP2;
                end
                CAP2: begin
                    // wp holds the oldest entry, i.e. x[t-3K] once the buffer is full.
                    rd_addr <= wp;
                    state   <= CAP1;
                end
                CAP1: begin
                    state <= CAP0;
                end
                CAP0: begin
                    packed_a0 <= mask_tap(rd_data, fill >= F_L);
                    packed_a1 <= stage1;
                    packed_a2 <= stage2;
                    packed_a3 <= stage3;
                    wp        <= addr_inc(wp);
                    fill      <= (fill == F_L) ? fill : fill + 1'b1;
                    out_v     <= 1'b1;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_activation_cache.sv
// Bench for activation_cache: two instances (DILATION=1 and DILATION=2) checked
// against a queue-based history model of the causal tap rule.
module tb_activation_cache;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] in1 = '0, in2 = '0;
    logic        v1 = 1'b0, v2 = 1'b0;
    logic        rdy1, rdy2, ov1, ov2;
    logic [63:0] a0_1, a1_1, a2_1, a3_1;
    logic [63:0] a0_2, a1_2, a2_2, a3_2;

    int checks = 0;
    int failures = 0;

    logic [63:0] q1[$];
    logic [63:0] q2[$];

    activation_cache #(.W(16), .D(4), .DILATION(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .packed_in(in1), .in_v(v1), .in_ready(rdy1),
        .packed_a0(a0_1), .packed_a1(a1_1), .packed_a2(a2_1), .packed_a3(a3_1), .out_v(ov1)
    );

    activation_cache #(.W(16), .D(4), .DILATION(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .packed_in(in2), .in_v(v2), .in_ready(rdy2),
        .packed_a0(a0_2), .packed_a1(a1_2), .packed_a2(a2_2), .packed_a3(a3_2), .out_v(ov2)
    );

    function automatic logic [63:0] rep(input int n);
        logic [15:0] e;
        e = 16'(n);
        return {e, e, e, e};
    endfunction

    function automatic logic [255:0] cur_taps(input int sel);
        return (sel == 1) ? {a3_1, a2_1, a1_1, a0_1} : {a3_2, a2_2, a1_2, a0_2};
    endfunction

    // Taps expected from the history: x[t-jK] if that many vectors have been seen, else zero.
    function automatic logic [255:0] exp_taps(input int sel);
        logic [255:0] r;
        logic [63:0]  e;
        int n, idx;
        r = '0;
        n = (sel == 1) ? q1.size() : q2.size();
        for (int j = 0; j < 4; j++) begin
            idx = n - 1 - j * sel;
            e = '0;
            if (idx >= 0) e = (sel == 1) ? q1[idx] : q2[idx];
            r[255 - 64*j -: 64] = e;
        end
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q1.delete();
        q2.delete();
    endtask

    // Offers one vector while idle and waits (bounded) for its taps.
    task automatic send(input int sel, input logic [63:0] vec,
                        output int lat, output int busy, output logic [255:0] taps);
        logic r, o;
        @(negedge clk);
        if (sel == 1) begin in1 = vec; v1 = 1'b1; end
        else          begin in2 = vec; v2 = 1'b1; end
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v2 = 1'b0;
        if (sel == 1) q1.push_back(vec); else q2.push_back(vec);
        lat = -1;
        busy = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            r = (sel == 1) ? rdy1 : rdy2;
            o = (sel == 1) ? ov1 : ov2;
            if (!r) busy++;
            if (o) begin lat = c; break; end
        end
        taps = cur_taps(sel);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy1, ov1, rdy2, ov2} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=1010", {rdy1, ov1, rdy2, ov2});
        end
        checks++;
        if ({cur_taps(1), cur_taps(2)} !== 512'h0) begin
            failures++;
            $display("FAIL reset_taps got=%h exp=0", {cur_taps(1), cur_taps(2)});
        end
        apply_reset();
    endtask

    task automatic test_first_vector();
        int lat, busy;
        logic [255:0] t;
        apply_reset();
        send(1, 64'h0001_0002_0003_0004, lat, busy, t);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL first_latency got=%0d exp=4", lat); end
        checks++;
        if (busy !== 4) begin failures++; $display("FAIL first_busy got=%0d exp=4", busy); end
        checks++;
        if (t !== {64'h0001_0002_0003_0004, 192'h0}) begin
            failures++;
            $display("FAIL first_taps got=%h exp=%h", t, {64'h0001_0002_0003_0004, 192'h0});
        end
    endtask

    task automatic test_stream(input int sel, input int count);
        int lat, busy;
        logic [255:0] t, e;
        apply_reset();
        for (int n = 1; n <= count; n++) begin
            send(sel, rep(n), lat, busy, t);
            e = exp_taps(sel);
            checks++;
            if (t !== e || lat !== 4) begin
                failures++;
                $display("FAIL stream_k%0d_n%0d got=%h lat=%0d exp=%h lat=4", sel, n, t, lat, e);
            end
            if (sel == 1 && n == 4) begin
                checks++;
                if (t !== {rep(4), rep(3), rep(2), rep(1)}) begin
                    failures++; $display("FAIL k1_after4 got=%h", t);
                end
            end
            if (sel == 1 && n == 6) begin
                checks++;
                if (t !== {rep(6), rep(5), rep(4), rep(3)}) begin
                    failures++; $display("FAIL k1_after6 got=%h", t);
                end
            end
            if (sel == 2 && n == 5) begin
                checks++;
                if (t !== {rep(5), rep(3), rep(1), 64'h0}) begin
                    failures++; $display("FAIL k2_after5 got=%h", t);
                end
            end
            if (sel == 2 && n == 10) begin
                checks++;
                if (t !== {rep(10), rep(8), rep(6), rep(4)}) begin
                    failures++; $display("FAIL k2_after10 got=%h", t);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev_acc, n_acc;
        logic prev_ov;
        logic [255:0] e;
        apply_reset();
        prev_acc = -1;
        n_acc = 0;
        prev_ov = ov1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            in1 = {$urandom, $urandom};
            v1 = 1'b1;
            if (rdy1) begin
                q1.push_back(in1);
                if (prev_acc >= 0) begin
                    checks++;
                    if (cyc - prev_acc !== 5) begin
                        failures++;
                        $display("FAIL b2b_spacing got=%0d exp=5", cyc - prev_acc);
                    end
                end
                prev_acc = cyc;
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (ov1 && !prev_ov) begin
                e = exp_taps(1);
                checks++;
                if (cur_taps(1) !== e) begin
                    failures++;
                    $display("FAIL b2b_taps got=%h exp=%h", cur_taps(1), e);
                end
            end
            prev_ov = ov1;
        end
        v1 = 1'b0;
        checks++;
        if (n_acc !== 12) begin failures++; $display("FAIL b2b_count got=%0d exp=12", n_acc); end
    endtask

    task automatic test_reset_mid();
        int lat, busy;
        logic [255:0] t;
        apply_reset();
        for (int n = 1; n <= 5; n++) send(1, rep(n), lat, busy, t);
        @(negedge clk);
        in1 = rep(6);
        v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cur_taps(1) !== 256'h0 || ov1 !== 1'b0 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL midreset_async got=%h ov=%b rdy=%b exp=0 ov=0 rdy=1", cur_taps(1), ov1, rdy1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q1.delete();
        q2.delete();
        send(1, 64'h7FFF_7FFF_7FFF_7FFF, lat, busy, t);
        checks++;
        if (t !== {64'h7FFF_7FFF_7FFF_7FFF, 192'h0} || lat !== 4) begin
            failures++;
            $display("FAIL midreset_next got=%h lat=%0d exp=%h lat=4", t, lat, {64'h7FFF_7FFF_7FFF_7FFF, 192'h0});
        end
    endtask

    task automatic test_sign_bits();
        int lat, busy;
        logic [255:0] t, e;
        logic [63:0] sv;
        sv = 64'h8000_FFFF_8000_FFFF;
        apply_reset();
        send(2, 64'h0123_4567_89AB_CDEF, lat, busy, t);
        send(2, sv, lat, busy, t);
        for (int s = 1; s <= 6; s++) begin
            send(2, {$urandom, $urandom}, lat, busy, t);
            e = exp_taps(2);
            checks++;
            if (t !== e) begin failures++; $display("FAIL sign_model_s%0d got=%h exp=%h", s, t, e); end
            if (s == 2) begin
                checks++;
                if (t[191:128] !== sv) begin failures++; $display("FAIL sign_a2 got=%h exp=%h", t[191:128], sv); end
            end
            if (s == 4) begin
                checks++;
                if (t[127:64] !== sv) begin failures++; $display("FAIL sign_a1 got=%h exp=%h", t[127:64], sv); end
            end
            if (s == 6) begin
                checks++;
                if (t[63:0] !== sv) begin failures++; $display("FAIL sign_a0 got=%h exp=%h", t[63:0], sv); end
            end
        end
    endtask

    task automatic test_random();
        int lat, busy, sel;
        logic [255:0] t, e;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(1, 2));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(sel, {$urandom, $urandom}, lat, busy, t);
            e = exp_taps(sel);
            checks++;
            if (t !== e || lat !== 4) begin
                failures++;
                $display("FAIL random_%0d_k%0d got=%h lat=%0d exp=%h", i, sel, t, lat, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_vector();
        test_stream(1, 6);
        test_stream(2, 10);
        test_back_to_back();
        test_reset_mid();
        test_sign_bits();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/activation_cache.md
Name: activation_cache

Overview:
- Upstream feeder for one dilated causal conv1d layer.
- Accepts one packed activation vector per timestep and keeps a circular history buffer of the last 3*DILATION vectors.
- Presents the four kernel taps: a3=x[t], a2=x[t-K], a1=x[t-2K], a0=x[t-3K], with K=DILATION, as packed ports that connect directly to the conv1d packed_a3..packed_a0 inputs.
- Taps older than the stream start read as zero (causal zero padding).

Parameters:
- W, 16: bits per element; signed fixed-point, passed through untouched.
- D, 4: elements per vector (the conv1d IN_D).
- DILATION, 1: tap spacing K in timesteps; must be >= 1. Buffer depth L = 3*DILATION entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- packed_in  in  D*W  new activation x[t]; element 0 in the MSBs.
- in_v  in  1  input valid; accepted only while in_ready=1.
- in_ready  out  1  high only in IDLE.
- packed_a0  out  D*W  x[t-3K], or 0 if not yet seen.
- packed_a1  out  D*W  x[t-2K], or 0 if not yet seen.
- packed_a2  out  D*W  x[t-K], or 0 if not yet seen.
- packed_a3  out  D*W  x[t].
- out_v  out  1  taps valid; high from completion until the next acceptance.

Behaviour:
- Reset (rst_n=0, async):
  - State IDLE; wp=0; fill=0; out_v=0; in_ready=1.
  - packed_a0..a3 = 0.
  - Buffer contents are not cleared; the fill count masks them.
- Storage: L x D*W memory, synchronous read (rd_data <= mem[rd_addr] every clock), single write port.
  - wp is the next write slot and always holds the oldest entry.
  - x[t-j] is at address (wp-j) mod L.
  - Address math is modulo L with explicit wrap; L need not be a power of 2.
- fill:
  - Counts vectors written, saturating at L.
  - Tap j*K (j=1..3) is valid iff fill >= j*K, using fill before the current write.
  - An invalid tap outputs all zeros.
- States: IDLE, FETCH, CAP2, CAP1, CAP0.
- IDLE:
  - On in_v: latch packed_in into stage3; rd_addr <= (wp-K) mod L; out_v <= 0; go to FETCH.
  - Without in_v: hold all outputs.
- FETCH: rd_addr <= (wp-2K) mod L; go to CAP2.
- CAP2: stage2 <= masked rd_data; rd_addr <= wp; go to CAP1.
- CAP1: stage1 <= masked rd_data; go to CAP0.
- CAP0, all in one edge:
  - packed_a0 <= masked rd_data.
  - packed_a1 <= stage1; packed_a2 <= stage2; packed_a3 <= stage3.
  - mem[wp] <= stage3; wp <= (wp+1) mod L; fill <= min(fill+1, L).
  - out_v <= 1; go to IDLE.
- Latency: acceptance edge E0, outputs and out_v=1 registered at E4.
  - Next acceptance possible at E5, so max throughput is 1 vector per 5 clocks.
- Output stability: packed_a* change only at the CAP0 edge; all four taps update atomically.
- Busy: in_ready=0 in FETCH..CAP0; in_v there is ignored (no queueing) and never corrupts the taps.
- Read/write hazard: the CAP0 write to wp occurs after the tap-3K read of wp (issued in CAP2, registered at the CAP1 edge), so the old value is read.
- DILATION=1: L=3, taps are consecutive timesteps; wp wraps 2->0.
- Reset mid-operation aborts the sequence; outputs zero immediately; the partial vector is discarded.
- No arithmetic is performed; values pass through bit-exact.

Test Plan:
- Reset then first vector (D=4, W=16, DILATION=1), packed_in=0x0001_0002_0003_0004:
  - -> out_v rises 4 clocks after acceptance.
  - -> a3 = that value; a2=a1=a0=0.
  - -> in_ready low for exactly 4 cycles.
- Stream x[n]={n,n,n,n} for n=1..6, DILATION=1:
  - -> after x[4]: a3=4, a2=3, a1=2, a0=1.
  - -> after x[6]: a3=6, a2=5, a1=4, a0=3 (wrap verified).
- DILATION=2 (L=6), stream n=1..10:
  - -> after x[5]: a3=5, a2=3, a1=1, a0=0 (masked, fill=4<6).
  - -> after x[10]: a3=10, a2=8, a1=6, a0=4.
- in_v held high continuously:
  - -> exactly one acceptance per 5 clocks.
  - -> in_v during busy cycles is ignored; the tap sequence is unchanged.
- rst_n pulsed low during CAP1 after 5 vectors:
  - -> outputs 0 and out_v=0 asynchronously.
  - -> next vector 0x7FFF.. yields a3=0x7FFF.., a2=a1=a0=0.
- Sign/bit-exact check with 0x8000 and 0xFFFF elements:
  - -> values reappear unchanged on a2/a1/a0 after K, 2K, 3K steps.
